// File: rtl/seq_ctrl_fsm_if.sv
// Sequencer bus: IR fields and status into the controller, datapath enables out.
// The master side drives the instruction fields; the slave side is seq_ctrl_fsm.
interface seq_ctrl_fsm_if #(
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] ADDR;
  logic [3:0]        OPCODE;
  logic              I_FLAG;
  logic [3:0]        ALU_FLAGS;
  logic              MEM_WAIT;

  logic [2:0]        PHASE;
  logic              IR_EN;
  logic              A_EN;
  logic              B_EN;
  logic              PDR_EN;
  logic              PORT_EN;
  logic              PORT_RD;
  logic              PC_EN;
  logic              PC_LOAD;
  logic              ALU_EN;
  logic              ALU_OE;
  logic              RAM_OE;
  logic              RDR_EN;
  logic              RAM_CS;
  logic              ILLEGAL;

  modport master (
    output ADDR, OPCODE, I_FLAG, ALU_FLAGS, MEM_WAIT,
    input  PHASE, IR_EN, A_EN, B_EN, PDR_EN, PORT_EN, PORT_RD, PC_EN, PC_LOAD,
           ALU_EN, ALU_OE, RAM_OE, RDR_EN, RAM_CS, ILLEGAL
  );

  modport slave (
    input  ADDR, OPCODE, I_FLAG, ALU_FLAGS, MEM_WAIT,
    output PHASE, IR_EN, A_EN, B_EN, PDR_EN, PORT_EN, PORT_RD, PC_EN, PC_LOAD,
           ALU_EN, ALU_OE, RAM_OE, RDR_EN, RAM_CS, ILLEGAL
  );
endinterface

// File: rtl/seq_ctrl_fsm.sv
// Registered phase sequencer for the Simple RISC-Y core: FETCH/DECODE/EXECUTE/UPDATE plus HALT.
// Define SEQ_CTRL_WAIT_EN to let MEM_WAIT stretch EXECUTE for RAM-touching instructions.
module seq_ctrl_fsm #(
  parameter int ADDR_W     = 7,
  parameter int REG_A_ADDR = 64,
  parameter int REG_B_ADDR = 65,
  parameter int PDR_ADDR   = 66,
  parameter int PORT_ADDR  = 67,
  parameter int RAM_LO     = 32,
  parameter int RAM_HI     = 63
) (
  input  logic          CLK,
  input  logic          RST,
  seq_ctrl_fsm_if.slave bus
);

  localparam logic [ADDR_W-1:0] A_ADDR_C    = ADDR_W'(REG_A_ADDR);
  localparam logic [ADDR_W-1:0] B_ADDR_C    = ADDR_W'(REG_B_ADDR);
  localparam logic [ADDR_W-1:0] PDR_ADDR_C  = ADDR_W'(PDR_ADDR);
  localparam logic [ADDR_W-1:0] PORT_ADDR_C = ADDR_W'(PORT_ADDR);
  localparam logic [ADDR_W-1:0] RAM_LO_C    = ADDR_W'(RAM_LO);
  localparam logic [ADDR_W-1:0] RAM_HI_C    = ADDR_W'(RAM_HI);

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_B     = 4'h8;
  localparam logic [3:0] OP_BZ    = 4'h9;
  localparam logic [3:0] OP_BN    = 4'hA;
  localparam logic [3:0] OP_BV    = 4'hB;
  localparam logic [3:0] OP_BC    = 4'hC;
  localparam logic [3:0] OP_UND_D = 4'hD;
  localparam logic [3:0] OP_UND_E = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_UPDATE  = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          opcode_q, opcode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                iflag_q, iflag_d;
  logic                branch_q, branch_d;
  logic                illegal_q, illegal_d;

  logic is_load, is_store, is_alu, is_undef;
  logic load_ok, port_hit, ram_hit, illegal_op, stretch;

  // ALU_FLAGS layout is {OF, SF, ZF, CF}.
  function automatic logic branch_taken(input logic [3:0] op, input logic [3:0] flags);
    case (op)
      OP_B:    branch_taken = 1'b1;
      OP_BZ:   branch_taken = flags[1];
      OP_BN:   branch_taken = flags[2];
      OP_BV:   branch_taken = flags[3];
      OP_BC:   branch_taken = flags[0];
      default: branch_taken = 1'b0;
    endcase
  endfunction

  always_comb begin
    is_load    = (opcode_q == OP_LOAD);
    is_store   = (opcode_q == OP_STORE);
    is_alu     = (opcode_q >= 4'h2) && (opcode_q <= 4'h7);
    is_undef   = (opcode_q == OP_UND_D) || (opcode_q == OP_UND_E);
    load_ok    = (addr_q == A_ADDR_C) || (addr_q == B_ADDR_C) ||
                 (addr_q == PDR_ADDR_C) || (addr_q == PORT_ADDR_C);
    port_hit   = (addr_q == PORT_ADDR_C);
    ram_hit    = (addr_q >= RAM_LO_C) && (addr_q <= RAM_HI_C);
    illegal_op = (is_load && !load_ok) || (is_store && !port_hit && !ram_hit) || is_undef;
  end

`ifdef SEQ_CTRL_WAIT_EN
  // Only instructions that actually touch the RAM may be held by a wait-state.
  logic wait_ok;
  assign wait_ok = (is_load && load_ok && !iflag_q) || (is_store && ram_hit);
  assign stretch = wait_ok && bus.MEM_WAIT;
`else
  logic unused_mem_wait;
  assign unused_mem_wait = bus.MEM_WAIT;
  assign stretch         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    addr_d    = addr_q;
    iflag_d   = iflag_q;
    branch_d  = branch_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = bus.OPCODE;
        addr_d   = bus.ADDR;
        iflag_d  = bus.I_FLAG;
        branch_d = branch_taken(bus.OPCODE, bus.ALU_FLAGS);
        state_d  = (bus.OPCODE == OP_HALT) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        if (!stretch) begin
          state_d   = S_UPDATE;
          illegal_d = illegal_q | illegal_op;
        end
      end
      S_UPDATE: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      addr_q    <= '0;
      iflag_q   <= 1'b0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      addr_q    <= addr_d;
      iflag_q   <= iflag_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs depend only on registered state, so reset forces the idle word immediately.
  always_comb begin
    bus.PHASE   = state_q;
    bus.ILLEGAL = illegal_q;
    bus.IR_EN   = 1'b0;
    bus.A_EN    = 1'b0;
    bus.B_EN    = 1'b0;
    bus.PDR_EN  = 1'b0;
    bus.PORT_EN = 1'b0;
    bus.PORT_RD = 1'b0;
    bus.PC_EN   = 1'b0;
    bus.PC_LOAD = 1'b0;
    bus.ALU_EN  = 1'b0;
    bus.ALU_OE  = 1'b0;
    bus.RAM_OE  = 1'b0;
    bus.RDR_EN  = 1'b0;
    bus.RAM_CS  = 1'b1;
    case (state_q)
      S_FETCH: begin
        bus.IR_EN  = 1'b1;
        bus.RAM_OE = 1'b1;
        bus.RAM_CS = 1'b0;
      end
      S_EXECUTE: begin
        if (is_load && load_ok) begin
          bus.A_EN    = (addr_q == A_ADDR_C);
          bus.B_EN    = (addr_q == B_ADDR_C);
          bus.PDR_EN  = (addr_q == PDR_ADDR_C);
          bus.PORT_EN = (addr_q == PORT_ADDR_C);
          if (!iflag_q) begin
            bus.RAM_OE = 1'b1;
            bus.RAM_CS = 1'b0;
          end
        end else if (is_store && port_hit) begin
          bus.PORT_RD = 1'b1;
        end else if (is_store && ram_hit) begin
          bus.ALU_OE = 1'b1;
          bus.RAM_CS = 1'b0;
        end else if (is_alu) begin
          bus.ALU_EN = 1'b1;
        end
      end
      S_UPDATE: begin
        bus.PC_EN   = 1'b1;
        bus.PC_LOAD = branch_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_ctrl_fsm.sv
// Directed plus randomized bench for seq_ctrl_fsm against a rule-level instruction model.
module tb_seq_ctrl_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_ctrl_fsm_if #(.ADDR_W(7)) bus ();

  seq_ctrl_fsm #(.ADDR_W(7)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

`ifdef SEQ_CTRL_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit ill_m  = 1'b0;

  // Bit order: IR_EN A_EN B_EN PDR_EN PORT_EN PORT_RD PC_EN PC_LOAD ALU_EN ALU_OE RAM_OE RDR_EN RAM_CS
  logic [12:0] act_word;
  assign act_word = {bus.IR_EN, bus.A_EN, bus.B_EN, bus.PDR_EN, bus.PORT_EN, bus.PORT_RD,
                     bus.PC_EN, bus.PC_LOAD, bus.ALU_EN, bus.ALU_OE, bus.RAM_OE, bus.RDR_EN,
                     bus.RAM_CS};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic bit in_rng(input int a, input int lo, input int hi);
    return (a >= lo) && (a <= hi);
  endfunction

  function automatic bit exp_branch(input int op, input logic [3:0] f);
    case (op)
      8:       return 1'b1;
      9:       return f[1];
      10:      return f[2];
      11:      return f[3];
      12:      return f[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit exp_illegal(input int op, input int addr);
    if (op == 13 || op == 14) return 1'b1;
    if (op == 0) return !in_rng(addr, 64, 67);
    if (op == 1) return !(addr == 67 || in_rng(addr, 32, 63));
    return 1'b0;
  endfunction

  function automatic bit exp_waitable(input int op, input int addr, input bit ifl);
    return (op == 0 && !ifl && in_rng(addr, 64, 67)) || (op == 1 && in_rng(addr, 32, 63));
  endfunction

  function automatic logic [12:0] exp_word(input int ph, input int op, input int addr,
                                           input bit ifl, input bit br);
    logic [12:0] w;
    w = 13'b0_0000_0000_0001;
    if (ph == 1) begin
      w[12] = 1'b1; w[2] = 1'b1; w[0] = 1'b0;
    end else if (ph == 3) begin
      if (op == 0 && in_rng(addr, 64, 67)) begin
        w[11 - (addr - 64)] = 1'b1;
        if (!ifl) begin w[2] = 1'b1; w[0] = 1'b0; end
      end else if (op == 1 && addr == 67) begin
        w[7] = 1'b1;
      end else if (op == 1 && in_rng(addr, 32, 63)) begin
        w[3] = 1'b1; w[0] = 1'b0;
      end else if (in_rng(op, 2, 7)) begin
        w[4] = 1'b1;
      end
    end else if (ph == 4) begin
      w[6] = 1'b1; w[5] = br;
    end
    return w;
  endfunction

  task automatic chk_all(input string tag, input int ph, input int op, input int addr,
                         input bit ifl, input bit br);
    chk({tag, "/phase"}, 16'(bus.PHASE), 16'(ph));
    chk({tag, "/enables"}, 16'(act_word), 16'(exp_word(ph, op, addr, ifl, br)));
    chk({tag, "/illegal"}, 16'(bus.ILLEGAL), 16'(ill_m));
  endtask

  task automatic scramble;
    bus.OPCODE    = 4'($urandom);
    bus.ADDR      = 7'($urandom);
    bus.I_FLAG    = 1'($urandom);
    bus.ALU_FLAGS = 4'($urandom);
    bus.MEM_WAIT  = 1'($urandom);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #1;
    ill_m = 1'b0;
    chk_all("reset", 0, 0, 0, 1'b0, 1'b0);
    step;
    chk_all("reset_hold", 0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk_all("released", 0, 0, 0, 1'b0, 1'b0);
    step;
  endtask

  // Entered in FETCH; leaves in FETCH (normal), HALT, or reset (abort).
  task automatic run_instr(input int op, input int addr, input bit ifl, input logic [3:0] fd,
                           input logic [3:0] fa, input int waits, input bit abort);
    bit br;
    chk_all("fetch", 1, op, addr, ifl, 1'b0);
    bus.OPCODE    = op[3:0];
    bus.ADDR      = addr[6:0];
    bus.I_FLAG    = ifl;
    bus.ALU_FLAGS = fd;
    bus.MEM_WAIT  = 1'($urandom);
    step;
    chk_all("decode", 2, op, addr, ifl, 1'b0);
    br = exp_branch(op, fd);
    step;
    scramble;
    bus.ALU_FLAGS = fa;
    if (op == 15) begin
      for (int i = 0; i < 20; i++) begin
        chk_all("halt", 5, op, addr, ifl, 1'b0);
        scramble;
        step;
      end
      return;
    end
    for (int i = 0; i <= waits; i++) begin
      chk_all("exec", 3, op, addr, ifl, br);
      if (abort) begin
        rst = 1'b1;
        #1;
        ill_m = 1'b0;
        chk_all("abort", 0, op, addr, ifl, br);
        return;
      end
      bus.MEM_WAIT = (i < waits);
      step;
      if (!(WAIT_EN && exp_waitable(op, addr, ifl) && (i < waits))) break;
    end
    if (exp_illegal(op, addr)) ill_m = 1'b1;
    chk_all("update", 4, op, addr, ifl, br);
    step;
  endtask

  initial begin
    int op, addr, sel;
    bus.OPCODE    = 4'h0;
    bus.ADDR      = 7'h0;
    bus.I_FLAG    = 1'b0;
    bus.ALU_FLAGS = 4'h0;
    bus.MEM_WAIT  = 1'b0;

    do_reset;
    run_instr(0, 64, 1'b1, 4'h0, 4'h0, 0, 1'b0);
    run_instr(0, 65, 1'b0, 4'h0, 4'h0, 0, 1'b0);
    run_instr(0, 70, 1'b0, 4'h0, 4'h0, 0, 1'b0);
    run_instr(1, 40, 1'b0, 4'h0, 4'h0, 2, 1'b0);
    run_instr(1, 67, 1'b0, 4'h0, 4'h0, 2, 1'b0);
    run_instr(9, 10, 1'b0, 4'b0010, 4'b0000, 0, 1'b0);
    run_instr(9, 10, 1'b0, 4'b0000, 4'b1111, 0, 1'b0);
    run_instr(13, 5, 1'b0, 4'h0, 4'h0, 1, 1'b0);
    run_instr(2, 0, 1'b0, 4'h0, 4'h0, 0, 1'b1);
    do_reset;

    for (int n = 0; n < 80; n++) begin
      op  = $urandom_range(0, 14);
      sel = $urandom_range(0, 7);
      if (sel <= 3)      addr = 64 + $urandom_range(0, 3);
      else if (sel == 4) addr = 32 + $urandom_range(0, 31);
      else if (sel == 5) addr = ($urandom_range(0, 2) == 0) ? 31 : (($urandom_range(0, 1) == 0) ? 63 : 68);
      else               addr = $urandom_range(0, 127);
      run_instr(op, addr, 1'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3), 1'b0);
    end

    run_instr(15, 0, 1'b0, 4'h0, 4'h0, 0, 1'b0);
    do_reset;
    run_instr(4, 0, 1'b0, 4'h0, 4'h0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_ctrl_fsm.md
# seq_ctrl_fsm

- Registered four-phase sequence controller for the Simple RISC-Y core. Successor to the combinational phase decoder.
- Owns an internal phase state machine (IDLE/FETCH/DECODE/EXECUTE/UPDATE/HALT) and latches the instruction fields and branch decision during DECODE.
- Parametrised in address width and register-file/RAM address map; adds memory wait-state, HALT opcode and a sticky illegal-access flag.
- Drives the control enables of the IR, A/B registers, port logic, PC, ALU and RAM.

## Interface
- ADDR_W, 7: width of the instruction address field.
- REG_A_ADDR, 64: load target for register A.
- REG_B_ADDR, 65: load target for register B.
- PDR_ADDR, 66: load target for the port direction register.
- PORT_ADDR, 67: IO port address, used for both load and store.
- RAM_LO, 32; RAM_HI, 63: inclusive data-RAM window, store only.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- ADDR  in  ADDR_W  IR address field.
- OPCODE  in  4  IR opcode.
- I_FLAG  in  1  immediate-mode bit.
- ALU_FLAGS  in  4  {OF,SF,ZF,CF}.
- MEM_WAIT  in  1  RAM not ready; stretches EXECUTE.
- PHASE  out  3  IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, UPDATE=4, HALT=5.
- IR_EN, A_EN, B_EN, PDR_EN, PORT_EN, PORT_RD, PC_EN, PC_LOAD, ALU_EN, ALU_OE, RAM_OE, RDR_EN  out  1 each  active-high enables.
- RAM_CS  out  1  active-low RAM select.
- ILLEGAL  out  1  sticky: illegal address or undefined opcode seen.

## Operation
- Opcodes: LOAD=0, STORE=1, ADD..NOT=2..7, B=8, BZ=9, BN=A, BV=B, BC=C, HALT=F. D and E are undefined.
- All outputs are decoded from the registered state and the DECODE-latched fields.
- Idle word (all outputs unless listed below): every enable 0, RAM_CS=1.
- State machine transitions:
  - IDLE -> FETCH -> DECODE.
  - DECODE -> HALT if OPCODE=F, else -> EXECUTE.
  - EXECUTE -> UPDATE, unless stretched by a wait (below).
  - UPDATE -> FETCH.
  - HALT is left only by RST.
- IDLE: idle word.
- FETCH: IR_EN=1, RAM_OE=1, RAM_CS=0.
- DECODE: idle word.
  - On the DECODE->next edge, latch OPCODE, ADDR and I_FLAG.
  - On the same edge, latch the branch decision: B always; BZ=ZF; BN=SF; BV=OF; BC=CF; all other opcodes 0.
- EXECUTE, LOAD:
  - Destination enable set by latched ADDR: A_EN, B_EN, PDR_EN or PORT_EN.
  - I_FLAG=0 (direct) additionally asserts RAM_OE=1, RAM_CS=0.
  - Any other ADDR: idle word, ILLEGAL set.
- EXECUTE, STORE:
  - ADDR=PORT_ADDR: PORT_RD=1.
  - RAM_LO<=ADDR<=RAM_HI: ALU_OE=1, RAM_CS=0, RAM_OE=0.
  - Any other ADDR: idle word, ILLEGAL set.
- EXECUTE, ALU opcodes 2-7: ALU_EN=1.
- EXECUTE, branch and undefined opcodes: idle word. Undefined opcodes also set ILLEGAL.
- UPDATE: PC_EN=1; PC_LOAD=1 if the latched branch decision is 1.
- HALT: idle word; PHASE=5.
- ILLEGAL sets on the EXECUTE->UPDATE edge and clears only on RST.
- Address comparisons are unsigned at full ADDR_W.

## Timing
- Reset (RST high, asynchronous): state=IDLE, latched fields=0, branch=0, ILLEGAL=0. All outputs take the idle word, PHASE=0.
- The first FETCH comes one cycle after RST deasserts.
- Nominal instruction time is 4 cycles (FETCH, DECODE, EXECUTE, UPDATE).
- Wait-state: MEM_WAIT is sampled at each EXECUTE edge, and only for direct LOAD and RAM STORE.
  - If MEM_WAIT=1, the state stays in EXECUTE with outputs unchanged.
  - Each wait cycle adds one cycle. There is no upper bound.
  - For every other instruction, MEM_WAIT is ignored.
- ALU_FLAGS are sampled only in DECODE; later flag changes do not affect the branch.
- RST mid-instruction aborts it immediately. No partial PC update.

## Configuration
- SEQ_CTRL_WAIT_EN defined: MEM_WAIT is honoured as described above.
- SEQ_CTRL_WAIT_EN undefined: MEM_WAIT is ignored and EXECUTE is always one cycle. The port remains present.

## Test plan
- Reset release:
  - PHASE sequence is 0,1,2,3,4,1 on consecutive cycles.
  - During the FETCH cycle: IR_EN=1, RAM_OE=1, RAM_CS=0.
- LOAD:
  - ADDR=64, I_FLAG=1 -> EXECUTE: A_EN=1, RAM_CS=1.
  - ADDR=65, I_FLAG=0 -> EXECUTE: B_EN=1, RAM_OE=1, RAM_CS=0.
  - ADDR=70 -> EXECUTE: idle word, ILLEGAL=1 from the UPDATE cycle onward.
- STORE:
  - ADDR=40 with MEM_WAIT=1 for 2 cycles -> EXECUTE lasts 3 cycles with ALU_OE=1, RAM_CS=0.
  - Rebuild without SEQ_CTRL_WAIT_EN -> EXECUTE lasts 1 cycle.
- BZ:
  - ZF=1 in DECODE, ZF=0 afterwards -> UPDATE: PC_EN=1, PC_LOAD=1.
  - BZ with ZF=0 -> PC_LOAD=0.
- HALT:
  - OPCODE=F -> PHASE=5 held for 20 cycles, all enables 0.
  - Pulse RST -> PHASE returns to 0, then 1.
- Async reset: assert RST mid-EXECUTE of an ADD -> ALU_EN drops in the same cycle, PHASE=0, ILLEGAL=0.
